// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter that shares one arilla peripheral bus among NumControllers controllers.
// Optional: define ARILLA_ARB_DEBUG_PRIORITY_EN to give controller 0 (debug module) absolute priority.
module arilla_bus_arbiter #(
  parameter int NumControllers   = 2,
  parameter int DataWidth        = 32,
  parameter int ByteAddressWidth = 32,
  parameter int ByteSize         = 8,
  parameter int MaxBurst         = 4,
  localparam int BytesPerWord     = DataWidth / ByteSize,
  localparam int WordAddressWidth = ByteAddressWidth - $clog2(BytesPerWord)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NumControllers*DataWidth-1:0]        c_data_ctp,
  input  logic [NumControllers*WordAddressWidth-1:0] c_address,
  input  logic [NumControllers*BytesPerWord-1:0]     c_byte_enable,
  input  logic [NumControllers-1:0]              c_read,
  input  logic [NumControllers-1:0]              c_write,
  output logic [NumControllers-1:0]              c_grant,
  output logic [DataWidth-1:0]                   c_data_ptc,
  output logic [NumControllers-1:0]              c_rvalid,
  output logic [NumControllers-1:0]              c_available,
  output logic [NumControllers-1:0]              c_intercept,
  output logic [DataWidth-1:0]                   p_data_ctp,
  output logic [WordAddressWidth-1:0]            p_address,
  output logic [BytesPerWord-1:0]                p_byte_enable,
  output logic                                   p_read,
  output logic                                   p_write,
  input  logic [DataWidth-1:0]                   p_data_ptc,
  input  logic                                   p_available,
  input  logic                                   p_intercept
);

  localparam int OwnerWidth = (NumControllers > 1) ? $clog2(NumControllers) : 1;
  localparam int CntWidth   = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                state, state_next;
  logic [OwnerWidth-1:0] owner, owner_next, rr_ptr, rr_ptr_next, resp_owner;
  logic [OwnerWidth-1:0] arb_base, arb_winner, arb_cand, ptr_after_owner;
  logic [CntWidth-1:0]   beat_cnt, beat_cnt_next;
  logic                  resp_pending;
  logic [NumControllers-1:0] req;
  logic owner_req, owner_rd, owner_wr, beat, burst_last, preempt, keep_ptr;
  logic release_own, arb_found;

  assign req             = c_read | c_write;
  assign owner_req       = req[owner];
  assign owner_rd        = c_read[owner];
  assign owner_wr        = c_write[owner] & ~c_read[owner];
  assign beat            = (state == OWNED) && owner_req;
  assign ptr_after_owner = OwnerWidth'((int'(owner) + 1) % NumControllers);

`ifdef ARILLA_ARB_DEBUG_PRIORITY_EN
  assign preempt    = req[0] && (owner != '0);
  assign burst_last = (owner != '0) && (beat_cnt == CntWidth'(MaxBurst - 1));
  assign keep_ptr   = (owner == '0);
`else
  assign preempt    = 1'b0;
  assign burst_last = (beat_cnt == CntWidth'(MaxBurst - 1));
  assign keep_ptr   = 1'b0;
`endif

  assign release_own = (state == OWNED) && (!owner_req || (beat && (burst_last || preempt)));
  // On release the search starts just past the old owner, so it competes last for the next slot.
  assign arb_base    = (state == OWNED && !keep_ptr) ? ptr_after_owner : rr_ptr;

  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_cand   = '0;
    for (int k = 0; k < NumControllers; k++) begin
      arb_cand = OwnerWidth'((int'(arb_base) + k) % NumControllers);
      if (!arb_found && req[arb_cand]) begin
        arb_found  = 1'b1;
        arb_winner = arb_cand;
      end
    end
`ifdef ARILLA_ARB_DEBUG_PRIORITY_EN
    if (req[0]) begin
      arb_found  = 1'b1;
      arb_winner = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      resp_pending <= 1'b0;
      resp_owner   <= '0;
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      rr_ptr       <= rr_ptr_next;
      beat_cnt     <= beat_cnt_next;
      resp_pending <= beat && owner_rd;
      resp_owner   <= owner;
    end
  end

  always_comb begin
    state_next    = state;
    owner_next    = owner;
    rr_ptr_next   = rr_ptr;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_next = OWNED;
          owner_next = arb_winner;
        end
      end
      OWNED: begin
        if (release_own) begin
          beat_cnt_next = '0;
          if (!keep_ptr) rr_ptr_next = ptr_after_owner;
          if (arb_found) owner_next = arb_winner;
          else           state_next = IDLE;
        end else if (beat) begin
          beat_cnt_next = beat_cnt + CntWidth'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The bus only carries the owner's request in cycles where a beat actually fires.
  always_comb begin
    c_grant       = '0;
    c_rvalid      = '0;
    c_available   = '0;
    c_intercept   = '0;
    c_data_ptc    = '0;
    p_data_ctp    = '0;
    p_address     = '0;
    p_byte_enable = '0;
    p_read        = 1'b0;
    p_write       = 1'b0;
    for (int i = 0; i < NumControllers; i++) begin
      if (beat && owner == OwnerWidth'(i)) begin
        c_grant[i]     = 1'b1;
        c_available[i] = p_available;
        c_intercept[i] = p_intercept;
        p_data_ctp     = c_data_ctp[i*DataWidth +: DataWidth];
        p_address      = c_address[i*WordAddressWidth +: WordAddressWidth];
        p_byte_enable  = c_byte_enable[i*BytesPerWord +: BytesPerWord];
      end
      if (resp_pending && resp_owner == OwnerWidth'(i)) c_rvalid[i] = 1'b1;
    end
    if (beat) begin
      p_read  = owner_rd;
      p_write = owner_wr;
    end
    if (resp_pending) c_data_ptc = p_data_ptc;
  end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed self-checking bench for arilla_bus_arbiter (2 controllers, MaxBurst 4).
// Cycle numbers in comments count from the first cycle a request is applied after reset.
module tb_arilla_bus_arbiter;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int WAW = 30;
  localparam int BPW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N*DW-1:0]  c_data_ctp;
  logic [N*WAW-1:0] c_address;
  logic [N*BPW-1:0] c_byte_enable;
  logic [N-1:0]     c_read, c_write, c_grant, c_rvalid, c_available, c_intercept;
  logic [DW-1:0]    c_data_ptc, p_data_ctp, p_data_ptc;
  logic [WAW-1:0]   p_address;
  logic [BPW-1:0]   p_byte_enable;
  logic             p_read, p_write, p_available, p_intercept;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_grant;

  arilla_bus_arbiter #(
    .NumControllers(N), .DataWidth(DW), .ByteAddressWidth(32), .ByteSize(8), .MaxBurst(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c_data_ctp(c_data_ctp), .c_address(c_address), .c_byte_enable(c_byte_enable),
    .c_read(c_read), .c_write(c_write), .c_grant(c_grant), .c_data_ptc(c_data_ptc),
    .c_rvalid(c_rvalid), .c_available(c_available), .c_intercept(c_intercept),
    .p_data_ctp(p_data_ctp), .p_address(p_address), .p_byte_enable(p_byte_enable),
    .p_read(p_read), .p_write(p_write), .p_data_ptc(p_data_ptc),
    .p_available(p_available), .p_intercept(p_intercept)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr);
    c_read  = rd;
    c_write = wr;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus('0, '0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    c_data_ctp    = '0;
    c_address     = '0;
    c_byte_enable = '0;
    p_data_ptc    = '0;
    p_available   = 1'b0;
    p_intercept   = 1'b0;
    do_reset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_grant", c_grant, 0);
    checkOutput("reset_rvalid", c_rvalid, 0);
    checkOutput("reset_p_rw", {p_read, p_write}, 0);
    checkOutput("reset_c_data_ptc", c_data_ptc, 0);
    rst_n = 1'b1;

    $display("[TB] single controller 1 continuous read");
    c_address[WAW +: WAW] = 30'h10;
    p_data_ptc  = 32'h1234_5678;
    p_available = 1'b1;
    next_cycle();
    applyStimulus(2'b10, 2'b00);
    checkOutput("a_c1_grant", c_grant, 0);
    for (int c = 2; c <= 9; c++) begin
      next_cycle();
      applyStimulus(2'b10, 2'b00);
      checkOutput($sformatf("a_c%0d_grant", c), c_grant, 2'b10);
      checkOutput($sformatf("a_c%0d_rvalid", c), c_rvalid, (c >= 3) ? 2'b10 : 2'b00);
      checkOutput($sformatf("a_c%0d_data", c), c_data_ptc, (c >= 3) ? 32'h1234_5678 : 32'h0);
      if (c == 2) begin
        checkOutput("a_p_read", p_read, 1);
        checkOutput("a_p_address", p_address, 30'h10);
        checkOutput("a_available", c_available, 2'b10);
      end
    end
    next_cycle();
    applyStimulus(2'b00, 2'b00);
    checkOutput("a_drop_grant", c_grant, 0);
    checkOutput("a_drop_rvalid", c_rvalid, 2'b10);
    next_cycle();
    checkOutput("a_after_rvalid", c_rvalid, 0);
    p_available = 1'b0;

    $display("[TB] two controllers alternate bursts");
    do_reset();
    next_cycle();
    applyStimulus(2'b00, 2'b11);
    checkOutput("b_c1_grant", c_grant, 0);
    for (int c = 2; c <= 13; c++) begin
      next_cycle();
      applyStimulus(2'b00, 2'b11);
      exp_grant = (((c - 2) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("b_c%0d_grant", c), c_grant, exp_grant);
      checkOutput($sformatf("b_c%0d_p_write", c), {p_read, p_write}, 2'b01);
    end

    $display("[TB] controller 0 single write");
    do_reset();
    c_data_ctp[0 +: DW]     = 32'hDEAD_BEEF;
    c_byte_enable[0 +: BPW] = 4'b0011;
    c_address[0 +: WAW]     = 30'h20;
    c_data_ctp[DW +: DW]    = 32'h1111_2222;
    c_byte_enable[BPW +: BPW] = 4'b1111;
    c_address[WAW +: WAW]   = 30'h30;
    p_intercept = 1'b1;
    next_cycle();
    applyStimulus(2'b00, 2'b01);
    checkOutput("c_idle_p_write", p_write, 0);
    next_cycle();
    applyStimulus(2'b00, 2'b01);
    checkOutput("c_p_write", p_write, 1);
    checkOutput("c_p_read", p_read, 0);
    checkOutput("c_p_data", p_data_ctp, 32'hDEAD_BEEF);
    checkOutput("c_p_be", p_byte_enable, 4'b0011);
    checkOutput("c_p_addr", p_address, 30'h20);
    checkOutput("c_intercept_granted", c_intercept, 2'b01);
    next_cycle();
    applyStimulus(2'b00, 2'b00);
    checkOutput("c_off_p_write", p_write, 0);
    checkOutput("c_off_grant", c_grant, 0);
    checkOutput("c_intercept_idle", c_intercept, 0);
    checkOutput("c_write_no_rvalid", c_rvalid, 0);
    p_intercept = 1'b0;

    $display("[TB] owner 1 releases early while controller 0 waits");
    do_reset();
    p_data_ptc = 32'hCAFE_0001;
    next_cycle();
    applyStimulus(2'b10, 2'b00);
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      applyStimulus(2'b10, 2'b00);
      checkOutput($sformatf("d_c%0d_grant", c), c_grant, 2'b10);
    end
    next_cycle();
    applyStimulus(2'b01, 2'b00);
    checkOutput("d_c4_grant", c_grant, 0);
    checkOutput("d_c4_rvalid", c_rvalid, 2'b10);
    next_cycle();
    applyStimulus(2'b01, 2'b00);
    checkOutput("d_c5_grant", c_grant, 2'b01);
    checkOutput("d_c5_rvalid", c_rvalid, 0);
    next_cycle();
    applyStimulus(2'b00, 2'b00);
    checkOutput("d_c6_rvalid", c_rvalid, 2'b01);
    checkOutput("d_c6_data", c_data_ptc, 32'hCAFE_0001);

    $display("[TB] reset pulse in the middle of a read");
    do_reset();
    next_cycle();
    applyStimulus(2'b01, 2'b00);
    next_cycle();
    applyStimulus(2'b01, 2'b00);
    checkOutput("e_c2_grant", c_grant, 2'b01);
    next_cycle();
    applyStimulus(2'b01, 2'b00);
    checkOutput("e_c3_rvalid", c_rvalid, 2'b01);
    rst_n = 1'b0;
    #1;
    checkOutput("e_rst_grant", c_grant, 0);
    checkOutput("e_rst_rvalid", c_rvalid, 0);
    checkOutput("e_rst_p_read", p_read, 0);
    checkOutput("e_rst_data", c_data_ptc, 0);
    next_cycle();
    applyStimulus(2'b00, 2'b00);
    rst_n = 1'b1;
    next_cycle();
    checkOutput("e_post_rvalid", c_rvalid, 0);
    checkOutput("e_post_grant", c_grant, 0);
    next_cycle();
    applyStimulus(2'b01, 2'b00);
    checkOutput("e_req_grant", c_grant, 0);
    next_cycle();
    applyStimulus(2'b01, 2'b00);
    checkOutput("e_first_grant", c_grant, 2'b01);

    $display("[TB] controller 0 requests while owner 1 is mid-burst");
    do_reset();
    next_cycle();
    applyStimulus(2'b10, 2'b00);
    for (int c = 2; c <= 13; c++) begin
      next_cycle();
      applyStimulus((c >= 3) ? 2'b11 : 2'b10, 2'b00);
`ifdef ARILLA_ARB_DEBUG_PRIORITY_EN
      exp_grant = (c <= 3) ? 2'b10 : 2'b01;
`else
      exp_grant = (c <= 5) ? 2'b10 : ((c <= 9) ? 2'b01 : 2'b10);
`endif
      checkOutput($sformatf("f_c%0d_grant", c), c_grant, exp_grant);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
